// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM burst scheduler: FSM state encoding and the
// helper that sizes the concatenated write/read port index.
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic int sched_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// N-request one-hot arbiter. RR_MODE=1 searches upward from a rotating pointer;
// RR_MODE=0 is plain lowest-index-wins.
module sdram_rr_arbiter
  import sdram_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int RR_MODE = 1,
  parameter int IW      = sched_idx_w(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         take_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;
  int            pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    gnt_o = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (RR_MODE != 0) ? int'(ptr_q) + k : k;
      if (pos >= N) pos = pos - N;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        idx        = IW'(pos);
        gnt_o[pos] = 1'b1;
      end
    end
  end

  assign any_o = found;
  assign ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (take_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// N-port burst scheduler: per-port address/length registers, eligibility, arbitration, one burst at a time.
// IDLE | waiting for an eligible port    REQ | CMD_REQ held until CMD_ACK    WAIT | data phase until XFER_DONE
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int NW       = 2,
  parameter int NR       = 2,
  parameter int ASIZE    = 22,
  parameter int LSIZE    = 9,
  parameter int RD_DEPTH = 512,
  parameter int RR_MODE  = 1,
  parameter int DEF_LEN  = 256
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NW-1:0]       WR_LOAD,
  input  logic [NW*ASIZE-1:0] WR_START,
  input  logic [NW*ASIZE-1:0] WR_MAX,
  input  logic [NW*LSIZE-1:0] WR_LEN,
  input  logic [NW*LSIZE-1:0] WR_LEVEL,
  input  logic [NR-1:0]       RD_LOAD,
  input  logic [NR*ASIZE-1:0] RD_START,
  input  logic [NR*ASIZE-1:0] RD_MAX,
  input  logic [NR*LSIZE-1:0] RD_LEN,
  input  logic [NR*LSIZE-1:0] RD_LEVEL,
  output logic                CMD_REQ,
  output logic                CMD_WRITE,
  output logic [ASIZE-1:0]    CMD_ADDR,
  output logic [LSIZE-1:0]    CMD_LEN,
  input  logic                CMD_ACK,
  input  logic                XFER_DONE,
  output logic [NW-1:0]       WR_GNT,
  output logic [NR-1:0]       RD_GNT,
  output logic                BUSY
);

  localparam int N = NW + NR;
  localparam logic [LSIZE:0]   DEPTH_E = (LSIZE + 1)'(RD_DEPTH);
  localparam logic [LSIZE-1:0] DEF_L   = LSIZE'(DEF_LEN);

  state_e           state_q, state_d;
  logic             cmd_write_q, cmd_write_d;
  logic [ASIZE-1:0] cmd_addr_q, cmd_addr_d;
  logic [LSIZE-1:0] cmd_len_q, cmd_len_d;
  logic [NW-1:0]    wr_gnt_q, wr_gnt_d;
  logic [NR-1:0]    rd_gnt_q, rd_gnt_d;

  logic [ASIZE-1:0] wr_addr_q [NW];
  logic [LSIZE-1:0] wr_len_q  [NW];
  logic [ASIZE-1:0] rd_addr_q [NR];
  logic [LSIZE-1:0] rd_len_q  [NR];

  logic [N-1:0] elig;
  logic [N-1:0] arb_gnt;
  logic         arb_any;
  logic         done_fire;

  // Wider arithmetic keeps max - len from wrapping; a region shorter than one burst always wraps.
  function automatic logic [ASIZE-1:0] next_addr(input logic [ASIZE-1:0] addr,
                                                 input logic [ASIZE-1:0] start,
                                                 input logic [ASIZE-1:0] max,
                                                 input logic [LSIZE-1:0] len);
    logic [ASIZE:0]   a_e, m_e, l_e;
    logic [ASIZE-1:0] res;
    a_e = {1'b0, addr};
    m_e = {1'b0, max};
    l_e = (ASIZE + 1)'(len);
    res = start;
    if ((m_e >= l_e) && (a_e < m_e - l_e)) res = addr + ASIZE'(len);
    return res;
  endfunction

  assign done_fire = (state_q == WAIT) && XFER_DONE;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NW; i++) begin
        wr_addr_q[i] <= '0;
        wr_len_q[i]  <= DEF_L;
      end
      for (int j = 0; j < NR; j++) begin
        rd_addr_q[j] <= '0;
        rd_len_q[j]  <= DEF_L;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (WR_LOAD[i]) begin
          wr_addr_q[i] <= WR_START[i*ASIZE +: ASIZE];
          wr_len_q[i]  <= WR_LEN[i*LSIZE +: LSIZE];
        end else if (done_fire && wr_gnt_q[i]) begin
          wr_addr_q[i] <= next_addr(wr_addr_q[i], WR_START[i*ASIZE +: ASIZE],
                                    WR_MAX[i*ASIZE +: ASIZE], wr_len_q[i]);
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (RD_LOAD[j]) begin
          rd_addr_q[j] <= RD_START[j*ASIZE +: ASIZE];
          rd_len_q[j]  <= RD_LEN[j*LSIZE +: LSIZE];
        end else if (done_fire && rd_gnt_q[j]) begin
          rd_addr_q[j] <= next_addr(rd_addr_q[j], RD_START[j*ASIZE +: ASIZE],
                                    RD_MAX[j*ASIZE +: ASIZE], rd_len_q[j]);
        end
      end
    end
  end

  // Read ports need room in their FIFO rather than data.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NW; i++) begin
      elig[i] = !WR_LOAD[i] && (wr_len_q[i] != '0) &&
                ({1'b0, WR_LEVEL[i*LSIZE +: LSIZE]} >= {1'b0, wr_len_q[i]});
    end
    for (int j = 0; j < NR; j++) begin
      elig[NW+j] = !RD_LOAD[j] && (rd_len_q[j] != '0) &&
                   ((DEPTH_E - {1'b0, RD_LEVEL[j*LSIZE +: LSIZE]}) >= {1'b0, rd_len_q[j]});
    end
  end

  sdram_rr_arbiter #(
    .N       (N),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .req_i  (elig),
    .take_i (state_q == IDLE),
    .gnt_o  (arb_gnt),
    .any_o  (arb_any)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wr_gnt_q    <= '0;
      rd_gnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      wr_gnt_q    <= wr_gnt_d;
      rd_gnt_q    <= rd_gnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    wr_gnt_d    = wr_gnt_q;
    rd_gnt_d    = rd_gnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d     = REQ;
          cmd_write_d = |arb_gnt[NW-1:0];
          cmd_addr_d  = '0;
          cmd_len_d   = '0;
          for (int i = 0; i < NW; i++) begin
            if (arb_gnt[i]) begin
              cmd_addr_d = wr_addr_q[i];
              cmd_len_d  = wr_len_q[i];
            end
          end
          for (int j = 0; j < NR; j++) begin
            if (arb_gnt[NW+j]) begin
              cmd_addr_d = rd_addr_q[j];
              cmd_len_d  = rd_len_q[j];
            end
          end
          wr_gnt_d = arb_gnt[NW-1:0];
          rd_gnt_d = arb_gnt[N-1:NW];
        end
      end
      REQ: begin
        if (CMD_ACK) state_d = WAIT;
      end
      WAIT: begin
        if (XFER_DONE) begin
          state_d  = IDLE;
          wr_gnt_d = '0;
          rd_gnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CMD_REQ   = (state_q == REQ);
  assign CMD_WRITE = cmd_write_q;
  assign CMD_ADDR  = cmd_addr_q;
  assign CMD_LEN   = cmd_len_q;
  assign WR_GNT    = wr_gnt_q;
  assign RD_GNT    = rd_gnt_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Scoreboard bench: expected bursts are queued ahead of stimulus, a monitor pops
// one on every CMD_REQ rising edge. A second fixed-priority instance runs alongside.
module tb_sdram_port_scheduler;

  localparam int NW = 2, NR = 2, ASIZE = 22, LSIZE = 9;

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic [NW-1:0]       WR_LOAD;
  logic [NW*ASIZE-1:0] WR_START, WR_MAX;
  logic [NW*LSIZE-1:0] WR_LEN, WR_LEVEL;
  logic [NR-1:0]       RD_LOAD;
  logic [NR*ASIZE-1:0] RD_START, RD_MAX;
  logic [NR*LSIZE-1:0] RD_LEN, RD_LEVEL;
  logic                CMD_ACK, XFER_DONE;

  logic             cmd_req, cmd_write, busy;
  logic [ASIZE-1:0] cmd_addr;
  logic [LSIZE-1:0] cmd_len;
  logic [NW-1:0]    wr_gnt;
  logic [NR-1:0]    rd_gnt;

  logic             fp_req, fp_write, fp_busy, fp_ack, fp_done;
  logic [ASIZE-1:0] fp_addr;
  logic [LSIZE-1:0] fp_len;
  logic [NW-1:0]    fp_wg;
  logic [NR-1:0]    fp_rg;

  typedef struct packed {
    logic             write;
    logic [ASIZE-1:0] addr;
    logic [LSIZE-1:0] len;
    logic [NW-1:0]    wg;
    logic [NR-1:0]    rg;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   fp_seen = 0;
  logic fp_window = 1'b0;
  logic mon_prev = 1'b0;
  logic fp_prev = 1'b0;

  always #5 CLK = ~CLK;

  sdram_port_scheduler #(.NW(NW), .NR(NR), .ASIZE(ASIZE), .LSIZE(LSIZE),
                         .RD_DEPTH(512), .RR_MODE(1), .DEF_LEN(256)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .WR_LOAD(WR_LOAD), .WR_START(WR_START), .WR_MAX(WR_MAX), .WR_LEN(WR_LEN), .WR_LEVEL(WR_LEVEL),
    .RD_LOAD(RD_LOAD), .RD_START(RD_START), .RD_MAX(RD_MAX), .RD_LEN(RD_LEN), .RD_LEVEL(RD_LEVEL),
    .CMD_REQ(cmd_req), .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
    .CMD_ACK(CMD_ACK), .XFER_DONE(XFER_DONE),
    .WR_GNT(wr_gnt), .RD_GNT(rd_gnt), .BUSY(busy));

  sdram_port_scheduler #(.NW(NW), .NR(NR), .ASIZE(ASIZE), .LSIZE(LSIZE),
                         .RD_DEPTH(512), .RR_MODE(0), .DEF_LEN(256)) u_fp (
    .CLK(CLK), .RESET(RESET),
    .WR_LOAD(WR_LOAD), .WR_START(WR_START), .WR_MAX(WR_MAX), .WR_LEN(WR_LEN), .WR_LEVEL(WR_LEVEL),
    .RD_LOAD(RD_LOAD), .RD_START(RD_START), .RD_MAX(RD_MAX), .RD_LEN(RD_LEN), .RD_LEVEL(RD_LEVEL),
    .CMD_REQ(fp_req), .CMD_WRITE(fp_write), .CMD_ADDR(fp_addr), .CMD_LEN(fp_len),
    .CMD_ACK(fp_ack), .XFER_DONE(fp_done),
    .WR_GNT(fp_wg), .RD_GNT(fp_rg), .BUSY(fp_busy));

  task automatic push(input logic w, input logic [ASIZE-1:0] a,
                      input logic [NW-1:0] wg, input logic [NR-1:0] rg);
    exp_t e;
    e.write = w;
    e.addr  = a;
    e.len   = 9'd256;
    e.wg    = wg;
    e.rg    = rg;
    exp_q.push_back(e);
  endtask

  // Monitor: every new request must match the oldest queued expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge CLK);
      if (cmd_req === 1'b1 && mon_prev !== 1'b1) begin
        a.write = cmd_write;
        a.addr  = cmd_addr;
        a.len   = cmd_len;
        a.wg    = wr_gnt;
        a.rg    = rd_gnt;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: got w=%0b addr=%h len=%0d wg=%b rg=%b, none expected",
                   a.write, a.addr, a.len, a.wg, a.rg);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL burst: got w=%0b addr=%h len=%0d wg=%b rg=%b, want w=%0b addr=%h len=%0d wg=%b rg=%b",
                     a.write, a.addr, a.len, a.wg, a.rg, e.write, e.addr, e.len, e.wg, e.rg);
          end
        end
      end
      mon_prev = cmd_req;
    end
  end

  // Fixed-priority instance: auto handshake; inside the window every grant must be W0.
  initial begin
    fp_ack  = 1'b0;
    fp_done = 1'b0;
    forever begin
      @(negedge CLK);
      fp_ack  = fp_req && fp_busy;
      fp_done = fp_busy && !fp_req;
      if (fp_req === 1'b1 && fp_prev !== 1'b1 && fp_window) begin
        checks++;
        fp_seen++;
        if (fp_wg !== 2'b01 || fp_rg !== 2'b00 || fp_write !== 1'b1) begin
          errors++;
          $display("FAIL fp_grant: got wg=%b rg=%b w=%0b, want wg=01 rg=00 w=1", fp_wg, fp_rg, fp_write);
        end
      end
      fp_prev = fp_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic wait_req_ack();
    int n = 0;
    while (cmd_req !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (cmd_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: CMD_REQ=%b after %0d cycles, want 1", cmd_req, n);
    end else begin
      CMD_ACK = 1'b1;
      @(negedge CLK);
      CMD_ACK = 1'b0;
    end
  endtask

  task automatic done_pulse(input logic [NW-1:0] load);
    @(negedge CLK);
    XFER_DONE = 1'b1;
    WR_LOAD   = WR_LOAD | load;
    @(negedge CLK);
    XFER_DONE = 1'b0;
    WR_LOAD   = WR_LOAD & ~load;
  endtask

  task automatic check_reset_outs(input string nm);
    checks++;
    if ({cmd_req, cmd_write, cmd_addr, cmd_len, wr_gnt, rd_gnt, busy} !== '0) begin
      errors++;
      $display("FAIL %s: got req=%b w=%b addr=%h len=%0d wg=%b rg=%b busy=%b, want all 0",
               nm, cmd_req, cmd_write, cmd_addr, cmd_len, wr_gnt, rd_gnt, busy);
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (cmd_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got req=%b busy=%b, want 0 0", nm, cmd_req, busy);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check_reset_outs("reset_hold");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_outs("reset_release");
  endtask

  initial begin
    WR_LOAD   = '0;
    RD_LOAD   = '0;
    WR_START  = '0;
    RD_START  = '0;
    WR_MAX    = {22'h3FFF00, 22'h3FFF00};
    RD_MAX    = {22'h3FFF00, 22'h3FFF00};
    WR_LEN    = {9'd256, 9'd256};
    RD_LEN    = {9'd256, 9'd256};
    WR_LEVEL  = '0;
    RD_LEVEL  = {9'd511, 9'd511};
    CMD_ACK   = 1'b0;
    XFER_DONE = 1'b0;
    @(negedge CLK);
    do_reset();

    // Single write port: one-cycle latency, then address advances by len.
    push(1'b1, 22'h0, 2'b01, 2'b00);
    push(1'b1, 22'h100, 2'b01, 2'b00);
    WR_LEVEL[0 +: LSIZE] = 9'd256;
    @(negedge CLK);
    checks++;
    if (cmd_req !== 1'b1 || wr_gnt !== 2'b01) begin
      errors++;
      $display("FAIL t1_latency: got req=%b wg=%b, want 1 01", cmd_req, wr_gnt);
    end
    wait_req_ack();
    done_pulse(2'b00);
    wait_req_ack();
    WR_LEVEL[0 +: LSIZE] = 9'd0;
    done_pulse(2'b00);
    repeat (4) @(negedge CLK);
    check_idle("t1_quiet");

    // Region wrap on W1 after four bursts.
    WR_START[ASIZE +: ASIZE] = 22'h100000;
    WR_MAX[ASIZE +: ASIZE]   = 22'h100400;
    WR_LOAD[1] = 1'b1;
    @(negedge CLK);
    WR_LOAD[1] = 1'b0;
    push(1'b1, 22'h100000, 2'b10, 2'b00);
    push(1'b1, 22'h100100, 2'b10, 2'b00);
    push(1'b1, 22'h100200, 2'b10, 2'b00);
    push(1'b1, 22'h100300, 2'b10, 2'b00);
    push(1'b1, 22'h100000, 2'b10, 2'b00);
    WR_LEVEL[LSIZE +: LSIZE] = 9'd256;
    for (int k = 0; k < 5; k++) begin
      wait_req_ack();
      if (k == 4) WR_LEVEL[LSIZE +: LSIZE] = 9'd0;
      done_pulse(2'b00);
    end
    repeat (4) @(negedge CLK);
    check_idle("t2_quiet");

    // Read free-space boundary: 255 free is too little, 256 is enough.
    RD_LEVEL[0 +: LSIZE] = 9'd257;
    repeat (6) @(negedge CLK);
    check_idle("t4_rd_257");
    push(1'b0, 22'h0, 2'b00, 2'b01);
    RD_LEVEL[0 +: LSIZE] = 9'd256;
    wait_req_ack();
    RD_LEVEL[0 +: LSIZE] = 9'd511;
    done_pulse(2'b00);
    repeat (4) @(negedge CLK);
    check_idle("t4_quiet");

    // Round-robin with everything eligible from a fresh pointer.
    do_reset();
    fp_window = 1'b1;
    push(1'b1, 22'h0,   2'b01, 2'b00);
    push(1'b1, 22'h0,   2'b10, 2'b00);
    push(1'b0, 22'h0,   2'b00, 2'b01);
    push(1'b0, 22'h0,   2'b00, 2'b10);
    push(1'b1, 22'h100, 2'b01, 2'b00);
    WR_LEVEL = {9'd256, 9'd256};
    RD_LEVEL = {9'd0, 9'd0};
    for (int k = 0; k < 5; k++) begin
      wait_req_ack();
      if (k == 4) begin
        WR_LEVEL = '0;
        RD_LEVEL = {9'd511, 9'd511};
      end
      done_pulse(2'b00);
    end
    repeat (6) @(negedge CLK);
    fp_window = 1'b0;
    checks++;
    if (fp_seen < 3) begin
      errors++;
      $display("FAIL fp_count: got %0d fixed-priority grants, want at least 3", fp_seen);
    end
    check_idle("t3_quiet");

    // LOAD coincident with done on W0: load wins; W1 served next.
    WR_START[0 +: ASIZE] = 22'h002000;
    push(1'b1, 22'h200, 2'b01, 2'b00);
    WR_LEVEL[0 +: LSIZE] = 9'd256;
    wait_req_ack();
    WR_LEVEL[0 +: LSIZE] = 9'd0;
    push(1'b1, 22'h100, 2'b10, 2'b00);
    WR_LEVEL[LSIZE +: LSIZE] = 9'd256;
    done_pulse(2'b01);
    wait_req_ack();
    WR_LEVEL[LSIZE +: LSIZE] = 9'd0;
    done_pulse(2'b00);
    push(1'b1, 22'h002000, 2'b01, 2'b00);
    WR_LEVEL[0 +: LSIZE] = 9'd256;
    wait_req_ack();
    WR_LEVEL[0 +: LSIZE] = 9'd0;
    done_pulse(2'b00);
    WR_LOAD[0] = 1'b1;
    push(1'b1, 22'h200, 2'b10, 2'b00);
    WR_LEVEL = {9'd256, 9'd256};
    wait_req_ack();
    WR_LEVEL = '0;
    done_pulse(2'b00);
    WR_LOAD[0] = 1'b0;
    repeat (4) @(negedge CLK);
    check_idle("t5_quiet");

    // Reset during the data phase clears everything and discards the update.
    push(1'b1, 22'h300, 2'b10, 2'b00);
    WR_LEVEL[LSIZE +: LSIZE] = 9'd256;
    wait_req_ack();
    WR_LEVEL[LSIZE +: LSIZE] = 9'd0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL t6_wait: got busy=%b req=%b, want 1 0", busy, cmd_req);
    end
    RESET = 1'b1;
    #1;
    check_reset_outs("t6_async_reset");
    @(negedge CLK);
    XFER_DONE = 1'b1;
    @(negedge CLK);
    XFER_DONE = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    push(1'b1, 22'h0, 2'b10, 2'b00);
    WR_LEVEL[LSIZE +: LSIZE] = 9'd256;
    wait_req_ack();
    WR_LEVEL[LSIZE +: LSIZE] = 9'd0;
    done_pulse(2'b00);
    repeat (4) @(negedge CLK);
    check_idle("final_quiet");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expect: got %0d unmatched expectations, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
